// File: rtl/hilo_control.sv
// hilo_control: architectural HI/LO register file and launch/wait controller
// for one iterative multiply or divide at a time. It stalls the control unit
// while an operation is outstanding, captures the 64-bit result when the
// selected unit's done level rises, aborts after a bounded wait, and serves
// MTHI/MTLO writes while idle.
module hilo_control #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        MultStart,
  input  logic        DivStart,
  input  logic        MultOut,
  input  logic [31:0] MultHi,
  input  logic [31:0] MultLo,
  input  logic        DivOut,
  input  logic [31:0] DivHi,
  input  logic [31:0] DivLo,
  input  logic        DivZero,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] WriteData,
  output logic        MultGo,
  output logic        DivGo,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        DivZeroErr,
  output logic        Timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MULT = 2'd1,
    WAIT_DIV  = 2'd2
  } state_t;

  // Last wait cycle before the abort fires.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             mult_prev_q;
  logic             div_prev_q;
  logic             mult_go_q;
  logic             div_go_q;
  logic             busy_q;
  logic             dz_err_q;
  logic             timeout_q;

  logic             mult_done;
  logic             div_done;
  logic             at_limit;

  // Completion is a rising edge of the done level, so a level left high from
  // a previous operation never counts as a fresh result.
  assign mult_done = MultOut & ~mult_prev_q;
  assign div_done  = DivOut  & ~div_prev_q;
  assign at_limit  = (cnt_q == CNT_LIMIT);
  assign cnt_d     = cnt_q + CNT_W'(1);

  // Previous-value registers for the done levels, updated every cycle.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      mult_prev_q <= 1'b0;
      div_prev_q  <= 1'b0;
    end else begin
      mult_prev_q <= MultOut;
      div_prev_q  <= DivOut;
    end
  end

  // Control FSM with registered outputs, HI/LO and the wait counter.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mult_go_q <= 1'b0;
      div_go_q  <= 1'b0;
      busy_q    <= 1'b0;
      dz_err_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // Launch and abort indications are single-cycle pulses by default.
      mult_go_q <= 1'b0;
      div_go_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Register moves are honoured alongside an accepted start.
          if (HiWrite) hi_q <= WriteData;
          if (LoWrite) lo_q <= WriteData;
          // Multiply takes priority when both starts arrive together.
          if (MultStart) begin
            state_q   <= WAIT_MULT;
            busy_q    <= 1'b1;
            mult_go_q <= 1'b1;
            cnt_q     <= '0;
            dz_err_q  <= 1'b0;
          end else if (DivStart) begin
            state_q  <= WAIT_DIV;
            busy_q   <= 1'b1;
            div_go_q <= 1'b1;
            cnt_q    <= '0;
            dz_err_q <= 1'b0;
          end
        end
        WAIT_MULT: begin
          // A result arriving on the limit cycle still beats the abort.
          if (mult_done) begin
            hi_q    <= MultHi;
            lo_q    <= MultLo;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (at_limit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_DIV: begin
          // Divide-by-zero leaves HI/LO intact and raises the sticky flag.
          if (div_done) begin
            if (DivZero) begin
              dz_err_q <= 1'b1;
            end else begin
              hi_q <= DivHi;
              lo_q <= DivLo;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (at_limit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign MultGo     = mult_go_q;
  assign DivGo      = div_go_q;
  assign Hi         = hi_q;
  assign Lo         = lo_q;
  assign Busy       = busy_q;
  assign DivZeroErr = dz_err_q;
  assign Timeout    = timeout_q;

endmodule

// File: tb/tb_hilo_control.sv
// Bench for hilo_control: reset state, a table of single-cycle vectors,
// hand-written multi-cycle sequences and a randomized run against a
// transaction-level reference model.
module tb_hilo_control;

  localparam int TO = 40;

  logic        clk;
  logic        Reset;
  logic        MultStart, DivStart, MultOut, DivOut, DivZero, HiWrite, LoWrite;
  logic [31:0] MultHi, MultLo, DivHi, DivLo, WriteData;
  logic        MultGo, DivGo, Busy, DivZeroErr, Timeout;
  logic [31:0] Hi, Lo;

  int n_vec = 0;
  int n_bad = 0;

  hilo_control #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .Reset(Reset),
    .MultStart(MultStart), .DivStart(DivStart),
    .MultOut(MultOut), .MultHi(MultHi), .MultLo(MultLo),
    .DivOut(DivOut), .DivHi(DivHi), .DivLo(DivLo), .DivZero(DivZero),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .MultGo(MultGo), .DivGo(DivGo), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .DivZeroErr(DivZeroErr), .Timeout(Timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  int          cyc;
  int          since;
  bit          m_mpend, m_dpend, m_mlast, m_dlast;
  logic [31:0] m_hi, m_lo;
  bit          m_busy, m_mgo, m_dgo, m_to, m_dze;

  task automatic model_reset();
    cyc = 0; since = 0;
    m_mpend = 0; m_dpend = 0; m_mlast = 0; m_dlast = 0;
    m_hi = '0; m_lo = '0;
    m_busy = 0; m_mgo = 0; m_dgo = 0; m_to = 0; m_dze = 0;
  endtask

  // One clock edge seen by the model, using the inputs held across the edge.
  task automatic model_step();
    bit mrise, drise;
    cyc++;
    mrise = MultOut && !m_mlast;
    drise = DivOut && !m_dlast;
    m_mgo = 0; m_dgo = 0; m_to = 0;
    if (!m_mpend && !m_dpend) begin
      if (HiWrite) m_hi = WriteData;
      if (LoWrite) m_lo = WriteData;
      if (MultStart) begin
        m_mpend = 1; since = cyc; m_mgo = 1; m_dze = 0;
      end else if (DivStart) begin
        m_dpend = 1; since = cyc; m_dgo = 1; m_dze = 0;
      end
    end else if (m_mpend && mrise) begin
      m_hi = MultHi; m_lo = MultLo; m_mpend = 0;
    end else if (m_dpend && drise) begin
      if (DivZero) m_dze = 1;
      else begin m_hi = DivHi; m_lo = DivLo; end
      m_dpend = 0;
    end else if (cyc - since == TO) begin
      m_to = 1; m_mpend = 0; m_dpend = 0;
    end
    m_mlast = MultOut;
    m_dlast = DivOut;
    m_busy  = m_mpend || m_dpend;
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (Reset) model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic ebusy, input logic emgo, input logic edgo,
                           input logic eto, input logic edze);
    check({tag, "_hi"}, Hi, ehi);
    check({tag, "_lo"}, Lo, elo);
    check_bit({tag, "_busy"}, Busy, ebusy);
    check_bit({tag, "_multgo"}, MultGo, emgo);
    check_bit({tag, "_divgo"}, DivGo, edgo);
    check_bit({tag, "_timeout"}, Timeout, eto);
    check_bit({tag, "_dzerr"}, DivZeroErr, edze);
  endtask

  task automatic clear_inputs();
    MultStart = 0; DivStart = 0; MultOut = 0; DivOut = 0; DivZero = 0;
    HiWrite = 0; LoWrite = 0;
    MultHi = '0; MultLo = '0; DivHi = '0; DivLo = '0; WriteData = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ms, ds, mo, dvo, dz, hw, lw;
    logic [31:0] a, b, wd;
    logic [31:0] e_hi, e_lo;
    logic        e_busy, e_mgo, e_dgo, e_to, e_dze;
  } vec_t;

  // ctl = {MultStart,DivStart,MultOut,DivOut,DivZero,HiWrite,LoWrite}
  // eo  = {Busy,MultGo,DivGo,Timeout,DivZeroErr}
  function automatic vec_t mk(input logic [6:0] ctl, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] wd, input logic [31:0] ehi,
                              input logic [31:0] elo, input logic [4:0] eo);
    vec_t v;
    {v.ms, v.ds, v.mo, v.dvo, v.dz, v.hw, v.lw} = ctl;
    v.a = a; v.b = b; v.wd = wd; v.e_hi = ehi; v.e_lo = elo;
    {v.e_busy, v.e_mgo, v.e_dgo, v.e_to, v.e_dze} = eo;
    return v;
  endfunction

  vec_t tbl[17];
  int   busy_cnt;
  int   rate;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(7'b0000010, 32'h0, 32'h0, 32'hDEAD, 32'hDEAD, 32'h0, 5'b00000);
    tbl[1]  = mk(7'b0000001, 32'h0, 32'h0, 32'hBEEF, 32'hDEAD, 32'hBEEF, 5'b00000);
    tbl[2]  = mk(7'b0000011, 32'h0, 32'h0, 32'h1234, 32'h1234, 32'h1234, 5'b00000);
    tbl[3]  = mk(7'b1000010, 32'h0, 32'h0, 32'h5555, 32'h5555, 32'h1234, 5'b11000);
    tbl[4]  = mk(7'b0000000, 32'h0, 32'h0, 32'h0, 32'h5555, 32'h1234, 5'b10000);
    tbl[5]  = mk(7'b0100010, 32'h0, 32'h0, 32'h9999, 32'h5555, 32'h1234, 5'b10000);
    tbl[6]  = mk(7'b0010000, 32'hAAAA0001, 32'hBBBB0002, 32'h0, 32'hAAAA0001, 32'hBBBB0002, 5'b00000);
    tbl[7]  = mk(7'b0110000, 32'h0, 32'h0, 32'h0, 32'hAAAA0001, 32'hBBBB0002, 5'b10100);
    tbl[8]  = mk(7'b0001000, 32'h7, 32'h3, 32'h0, 32'h7, 32'h3, 5'b00000);
    tbl[9]  = mk(7'b0101000, 32'h0, 32'h0, 32'h0, 32'h7, 32'h3, 5'b10100);
    tbl[10] = mk(7'b0001100, 32'hFF, 32'hEE, 32'h0, 32'h7, 32'h3, 5'b10000);
    tbl[11] = mk(7'b0000000, 32'h0, 32'h0, 32'h0, 32'h7, 32'h3, 5'b10000);
    tbl[12] = mk(7'b0001100, 32'hFF, 32'hEE, 32'h0, 32'h7, 32'h3, 5'b00001);
    tbl[13] = mk(7'b0000000, 32'h0, 32'h0, 32'h0, 32'h7, 32'h3, 5'b00001);
    tbl[14] = mk(7'b1100000, 32'h0, 32'h0, 32'h0, 32'h7, 32'h3, 5'b11000);
    tbl[15] = mk(7'b0001000, 32'h11, 32'h22, 32'h0, 32'h7, 32'h3, 5'b10000);
    tbl[16] = mk(7'b0010000, 32'h1, 32'h2, 32'h0, 32'h1, 32'h2, 5'b00000);

    // Reset state
    clear_inputs();
    Reset = 1'b0;
    model_reset();
    #1;
    check_all("reset", 32'h0, 32'h0, 0, 0, 0, 0, 0);
    tick(); tick();
    Reset = 1'b1;
    tick();
    check_all("post_reset", 32'h0, 32'h0, 0, 0, 0, 0, 0);

    // Table vectors, one clock each
    for (int i = 0; i < 17; i++) begin
      MultStart = tbl[i].ms; DivStart = tbl[i].ds;
      MultOut = tbl[i].mo; DivOut = tbl[i].dvo; DivZero = tbl[i].dz;
      HiWrite = tbl[i].hw; LoWrite = tbl[i].lw; WriteData = tbl[i].wd;
      MultHi = tbl[i].a; DivHi = tbl[i].a; MultLo = tbl[i].b; DivLo = tbl[i].b;
      tick();
      check_all($sformatf("tbl%0d", i), tbl[i].e_hi, tbl[i].e_lo, tbl[i].e_busy,
                tbl[i].e_mgo, tbl[i].e_dgo, tbl[i].e_to, tbl[i].e_dze);
    end
    clear_inputs();
    tick();

    // Multiply completing 33 cycles after launch
    MultStart = 1; tick(); MultStart = 0;
    check_bit("t2_multgo", MultGo, 1'b1);
    check_bit("t2_busy0", Busy, 1'b1);
    busy_cnt = Busy ? 1 : 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (Busy) busy_cnt++;
      if (i == 1) check_bit("t2_multgo_off", MultGo, 1'b0);
    end
    MultHi = 32'h1; MultLo = 32'h2; MultOut = 1;
    tick();
    check_bit("t2_busy_done", Busy, 1'b0);
    check("t2_hi", Hi, 32'h1);
    check("t2_lo", Lo, 32'h2);
    check("t2_busy_cycles", busy_cnt, 33);

    // Timeout with no completion, then completion on the limit cycle
    MultOut = 0; tick();
    MultStart = 1; tick(); MultStart = 0;
    for (int i = 1; i <= TO - 1; i++) begin
      tick();
      check_bit("t4_no_timeout", Timeout, 1'b0);
      check_bit("t4_busy", Busy, 1'b1);
    end
    tick();
    check_bit("t4_timeout", Timeout, 1'b1);
    check_bit("t4_idle", Busy, 1'b0);
    check("t4_hi_kept", Hi, 32'h1);
    check("t4_lo_kept", Lo, 32'h2);
    tick();
    check_bit("t4_timeout_pulse", Timeout, 1'b0);
    MultStart = 1; tick(); MultStart = 0;
    for (int i = 1; i <= TO - 1; i++) tick();
    MultHi = 32'hCAFE; MultLo = 32'hF00D; MultOut = 1;
    tick();
    check_bit("t4b_no_timeout", Timeout, 1'b0);
    check_bit("t4b_idle", Busy, 1'b0);
    check("t4b_hi", Hi, 32'hCAFE);
    check("t4b_lo", Lo, 32'hF00D);

    // Divide by zero keeps HI/LO and sets the sticky flag
    MultOut = 0;
    HiWrite = 1; LoWrite = 1; WriteData = 32'hA5A5A5A5;
    tick();
    HiWrite = 0; LoWrite = 0;
    check("t3_preset_hi", Hi, 32'hA5A5A5A5);
    DivStart = 1; tick(); DivStart = 0;
    check_bit("t3_divgo", DivGo, 1'b1);
    tick();
    DivOut = 1; DivZero = 1; DivHi = 32'h1111; DivLo = 32'h2222;
    tick();
    check("t3_hi", Hi, 32'hA5A5A5A5);
    check("t3_lo", Lo, 32'hA5A5A5A5);
    check_bit("t3_dzerr", DivZeroErr, 1'b1);
    check_bit("t3_idle", Busy, 1'b0);
    DivOut = 0; DivZero = 0;
    tick();
    check_bit("t3_dzerr_sticky", DivZeroErr, 1'b1);
    MultStart = 1; tick(); MultStart = 0;
    check_bit("t3_dzerr_clear", DivZeroErr, 1'b0);
    check_bit("t3_busy", Busy, 1'b1);

    // Asynchronous reset in the middle of a multiply wait
    tick(); tick();
    #2;
    Reset = 0;
    model_reset();
    #1;
    check_bit("t1_busy", Busy, 1'b0);
    check("t1_hi", Hi, 32'h0);
    check("t1_lo", Lo, 32'h0);
    tick();
    Reset = 1;
    MultHi = 32'h77; MultLo = 32'h88; MultOut = 1;
    tick();
    check_bit("t1_busy_after", Busy, 1'b0);
    check("t1_hi_after", Hi, 32'h0);
    check("t1_lo_after", Lo, 32'h0);

    // Randomized run against the reference model
    clear_inputs();
    tick();
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 500) % 2 == 0) ? 10 : 60;
      MultStart = ($urandom_range(0, 5) == 0);
      DivStart  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, rate - 1) == 0) MultOut = ~MultOut;
      if ($urandom_range(0, rate - 1) == 0) DivOut = ~DivOut;
      DivZero   = ($urandom_range(0, 3) == 0);
      HiWrite   = ($urandom_range(0, 3) == 0);
      LoWrite   = ($urandom_range(0, 3) == 0);
      MultHi = $urandom; MultLo = $urandom;
      DivHi  = $urandom; DivLo  = $urandom;
      WriteData = $urandom;
      tick();
      check_all("rnd", m_hi, m_lo, m_busy, m_mgo, m_dgo, m_to, m_dze);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
